flag_status_register: RTL and testbench

- Consumer end of the ALU flag interface. Latches the ALU's N/Z/C/V outputs into an architectural status register under a per-flag write mask.
- Feeds the stored carry back to the ALU carry input.
- Evaluates ARM 4-bit condition fields for the control unit through a valid/ready query handshake with a one-entry registered result buffer.
- Keeps a saturating count of condition-failed queries for debug.

---
 rtl/flag_status_register.sv | 121 ++++++++++++
 tb/tb_flag_status_register.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_status_register.sv
// flag_status_register
//   Architectural NZCV status register fed by the ALU, with a condition-code
//   evaluator serving the control unit through a valid/ready query handshake
//   and a one-entry registered result buffer.
//
// Ports
//   clk, resetN                 clock (rising edge), async active-low reset
//   flagsUpdate, updateMask     masked flag write strobe / per-flag enable {N,Z,C,V}
//   nFlagIn..vFlagIn            flag values from the ALU
//   condValid, condCode         condition query and its 4-bit ARM condition field
//   condReady                   query can be accepted this cycle
//   resultValid, condResult     buffered result (1 = condition passed)
//   resultAck                   consumer takes the buffered result
//   flagsOut, carryOut          stored {N,Z,C,V}; stored C back to the ALU
//   failCount                   saturating count of accepted queries that failed
module flag_status_register #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flagsUpdate,
    input  logic [3:0]       updateMask,
    input  logic             nFlagIn,
    input  logic             zFlagIn,
    input  logic             cFlagIn,
    input  logic             vFlagIn,
    input  logic             condValid,
    input  logic [3:0]       condCode,
    output logic             condReady,
    output logic             resultValid,
    output logic             condResult,
    input  logic             resultAck,
    output logic [3:0]       flagsOut,
    output logic             carryOut,
    output logic [CNT_W-1:0] failCount
);

    logic [3:0]       flags_q, flags_d;
    logic             result_valid_q, result_valid_d;
    logic             cond_result_q, cond_result_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    // Low from reset until the first edge after release, so a query
    // presented across the release edge is not captured.
    logic             armed_q, armed_d;

    logic [3:0] flags_fwd;
    logic       cond_pass;
    logic       accept;
    logic       n_f, z_f, c_f, v_f;

    always_comb begin
        // Forward a same-cycle flag write so the query sees the new flags.
        flags_fwd = flagsUpdate
                  ? ((flags_q & ~updateMask) | ({nFlagIn, zFlagIn, cFlagIn, vFlagIn} & updateMask))
                  : flags_q;
        {n_f, z_f, c_f, v_f} = flags_fwd;

        cond_pass = 1'b0;
        case (condCode)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f & !z_f;
            4'b1001: cond_pass = !c_f | z_f;
            4'b1010: cond_pass = (n_f == v_f);
            4'b1011: cond_pass = (n_f != v_f);
            4'b1100: cond_pass = !z_f & (n_f == v_f);
            4'b1101: cond_pass = z_f | (n_f != v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase

        condReady = !result_valid_q | resultAck;
        accept    = condValid & condReady & armed_q;

        flags_d        = flags_fwd;
        armed_d        = 1'b1;
        result_valid_d = result_valid_q;
        cond_result_d  = cond_result_q;
        fail_count_d   = fail_count_q;

        if (accept) begin
            result_valid_d = 1'b1;
            cond_result_d  = cond_pass;
            if (!cond_pass && (fail_count_q != {CNT_W{1'b1}}))
                fail_count_d = fail_count_q + CNT_W'(1);
        end else if (resultAck) begin
            // Drain only; condResult keeps its last value.
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flags_q        <= RESET_FLAGS;
            result_valid_q <= 1'b0;
            cond_result_q  <= 1'b0;
            fail_count_q   <= '0;
            armed_q        <= 1'b0;
        end else begin
            flags_q        <= flags_d;
            result_valid_q <= result_valid_d;
            cond_result_q  <= cond_result_d;
            fail_count_q   <= fail_count_d;
            armed_q        <= armed_d;
        end
    end

    assign resultValid = result_valid_q;
    assign condResult  = cond_result_q;
    assign flagsOut    = flags_q;
    assign carryOut    = flags_q[1];
    assign failCount   = fail_count_q;

endmodule

// File: tb/tb_flag_status_register.sv
// Bench for flag_status_register: two instances share one stimulus stream
// (A: RESET_FLAGS=0010, CNT_W=16; B: RESET_FLAGS=0000, CNT_W=2). Directed
// steps follow the test plan, then a random phase; every output of both
// instances is compared against a transaction-level model after each edge.
module tb_flag_status_register;

    logic       clk = 1'b0;
    logic       resetN;
    logic       flagsUpdate;
    logic [3:0] updateMask;
    logic       nFlagIn, zFlagIn, cFlagIn, vFlagIn;
    logic       condValid;
    logic [3:0] condCode;
    logic       resultAck;

    logic        rdy_a, rv_a, res_a, co_a;
    logic [3:0]  fl_a;
    logic [15:0] fc_a;
    logic        rdy_b, rv_b, res_b, co_b;
    logic [3:0]  fl_b;
    logic [1:0]  fc_b;

    always #5 clk = ~clk;

    flag_status_register #(.RESET_FLAGS(4'b0010), .CNT_W(16)) dut_a (
        .clk(clk), .resetN(resetN), .flagsUpdate(flagsUpdate), .updateMask(updateMask),
        .nFlagIn(nFlagIn), .zFlagIn(zFlagIn), .cFlagIn(cFlagIn), .vFlagIn(vFlagIn),
        .condValid(condValid), .condCode(condCode), .condReady(rdy_a),
        .resultValid(rv_a), .condResult(res_a), .resultAck(resultAck),
        .flagsOut(fl_a), .carryOut(co_a), .failCount(fc_a));

    flag_status_register #(.RESET_FLAGS(4'b0000), .CNT_W(2)) dut_b (
        .clk(clk), .resetN(resetN), .flagsUpdate(flagsUpdate), .updateMask(updateMask),
        .nFlagIn(nFlagIn), .zFlagIn(zFlagIn), .cFlagIn(cFlagIn), .vFlagIn(vFlagIn),
        .condValid(condValid), .condCode(condCode), .condReady(rdy_b),
        .resultValid(rv_b), .condResult(res_b), .resultAck(resultAck),
        .flagsOut(fl_b), .carryOut(co_b), .failCount(fc_b));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    bit [3:0] m_f[2];
    bit       m_rv[2], m_res[2], m_armed[2];
    int       m_fc[2];
    int       m_cap[2]  = '{65535, 3};
    bit [3:0] m_rst[2]  = '{4'b0010, 4'b0000};
    bit       m_acc;

    // Conditions come in pass/fail pairs: odd codes invert the even one.
    function automatic bit model_eval(bit [3:0] code, bit [3:0] f);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (code == 4'hF) ? 1'b0 : (base ^ code[0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_f[i] = m_rst[i]; m_rv[i] = 0; m_res[i] = 0; m_fc[i] = 0; m_armed[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit [3:0] fin, nf;
        bit rdy, acc;
        fin = {nFlagIn, zFlagIn, cFlagIn, vFlagIn};
        for (int i = 0; i < 2; i++) begin
            nf  = flagsUpdate ? ((m_f[i] & ~updateMask) | (fin & updateMask)) : m_f[i];
            rdy = !m_rv[i] || resultAck;
            acc = condValid && rdy && m_armed[i];
            if (acc) begin
                m_res[i] = model_eval(condCode, nf);
                m_rv[i]  = 1;
                if (!m_res[i] && m_fc[i] < m_cap[i]) m_fc[i]++;
            end else if (resultAck) begin
                m_rv[i] = 0;
            end
            m_f[i] = nf;
            m_armed[i] = 1;
            m_acc = acc;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".a.flags"}, 32'(fl_a), 32'(m_f[0]));
        chk({tag, ".a.carry"}, 32'(co_a), 32'(m_f[0][1]));
        chk({tag, ".a.rv"},    32'(rv_a), 32'(m_rv[0]));
        chk({tag, ".a.res"},   32'(res_a), 32'(m_res[0]));
        chk({tag, ".a.rdy"},   32'(rdy_a), 32'(!m_rv[0] || resultAck));
        chk({tag, ".a.fc"},    32'(fc_a), 32'(m_fc[0]));
        chk({tag, ".b.flags"}, 32'(fl_b), 32'(m_f[1]));
        chk({tag, ".b.carry"}, 32'(co_b), 32'(m_f[1][1]));
        chk({tag, ".b.rv"},    32'(rv_b), 32'(m_rv[1]));
        chk({tag, ".b.res"},   32'(res_b), 32'(m_res[1]));
        chk({tag, ".b.rdy"},   32'(rdy_b), 32'(!m_rv[1] || resultAck));
        chk({tag, ".b.fc"},    32'(fc_b), 32'(m_fc[1]));
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drv(bit upd, bit [3:0] msk, bit [3:0] nzcv, bit cv, bit [3:0] cc, bit ack);
        flagsUpdate = upd; updateMask = msk;
        {nFlagIn, zFlagIn, cFlagIn, vFlagIn} = nzcv;
        condValid = cv; condCode = cc; resultAck = ack;
    endtask

    // Reset asserted mid-cycle and checked before any edge; released mid-cycle.
    task automatic do_reset(string tag);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    bit [3:0] gtle_codes[6] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    bit       gtle_exp[6]   = '{0, 1, 0, 1, 1, 0};

    initial begin
        resetN = 1'b1;
        drv(0, 4'h0, 4'h0, 0, 4'h0, 0);
        m_acc = 0;
        #2;
        do_reset("rst");
        chk("tp1.flags", 32'(fl_a), 32'h2);
        chk("tp1.carry", 32'(co_a), 32'h1);
        chk("tp1.rdy",   32'(rdy_a), 32'h1);

        // Query held across the release edge is not captured there.
        drv(0, 4'h0, 4'h0, 1, 4'b1110, 0);
        step("rel0");
        chk("rel.no_capture", 32'(rv_a), 32'h0);
        step("rel1");
        chk("rel.capture", 32'(rv_a), 32'h1);
        drv(0, 4'h0, 4'h0, 0, 4'h0, 1);
        step("rel2");

        // Masked write: only N and Z change.
        drv(1, 4'b1100, 4'b1101, 0, 4'h0, 0);
        step("tp2");
        chk("tp2.flags", 32'(fl_a), 32'hE);

        // Full write to Z-only plus same-cycle EQ sees the new flags.
        drv(1, 4'b1111, 4'b0100, 1, 4'b0000, 1);
        step("tp3a");
        chk("tp3.eq_fwd", 32'(res_a), 32'h1);
        drv(0, 4'h0, 4'h0, 1, 4'b0001, 1);
        step("tp3b");
        chk("tp3.ne", 32'(res_a), 32'h0);
        chk("tp3.fc", 32'(fc_a), 32'h1);

        // N=1, V=0: signed comparisons back-to-back.
        drv(1, 4'b1111, 4'b1000, 0, 4'h0, 1);
        step("tp4set");
        for (int i = 0; i < 6; i++) begin
            drv(0, 4'h0, 4'h0, 1, gtle_codes[i], 1);
            step("tp4q");
            chk("tp4.res", 32'(res_a), 32'(gtle_exp[i]));
            chk("tp4.rv",  32'(rv_a), 32'h1);
        end
        chk("tp4.fc", 32'(fc_a), 32'h4);

        // Backpressure: result held, new query waits, then drain+accept.
        drv(0, 4'h0, 4'h0, 1, 4'b0101, 0);
        step("tp5acc");
        drv(0, 4'h0, 4'h0, 1, 4'b0100, 0);
        for (int i = 0; i < 3; i++) begin
            step("tp5hold");
            chk("tp5.rdy", 32'(rdy_a), 32'h0);
            chk("tp5.res_held", 32'(res_a), 32'h0);
        end
        resultAck = 1;
        step("tp5drain");
        chk("tp5.new_res", 32'(res_a), 32'h1);
        drv(0, 4'h0, 4'h0, 0, 4'h0, 1);
        step("tp5idle");

        // Saturation on the narrow counter, then reset with a result held.
        do_reset("rst2");
        drv(0, 4'h0, 4'h0, 0, 4'h0, 1);
        step("tp6arm");
        drv(0, 4'h0, 4'h0, 1, 4'b1111, 1);
        for (int i = 0; i < 5; i++) step("tp6nv");
        chk("tp6.sat_b", 32'(fc_b), 32'h3);
        chk("tp6.cnt_a", 32'(fc_a), 32'h5);
        resultAck = 0;
        step("tp6held");
        #2;
        resetN = 1'b0;
        #1;
        chk("tp6.rst_rv", 32'(rv_b), 32'h0);
        chk("tp6.rst_fc", 32'(fc_b), 32'h0);
        chk("tp6.rst_fl", 32'(fl_a), 32'h2);
        model_reset();
        drv(0, 4'h0, 4'h0, 0, 4'h0, 0);
        @(negedge clk);
        resetN = 1'b1;

        // Random traffic; a pending query stays stable until accepted.
        for (int k = 0; k < 400; k++) begin
            flagsUpdate = 1'($urandom);
            updateMask  = 4'($urandom);
            {nFlagIn, zFlagIn, cFlagIn, vFlagIn} = 4'($urandom);
            resultAck   = ($urandom_range(0, 3) != 0);
            if (!(condValid && !m_acc)) begin
                condValid = ($urandom_range(0, 3) != 0);
                condCode  = 4'($urandom);
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
